load_store_unit: RTL and testbench

//  Data-memory access stage that directly consumes the control unit's MemWrite, operation_byte_size and MemResultCtr.

---
 rtl/load_store_unit_pkg.sv | 29 ++
 rtl/lsu_lane_align.sv | 48 ++++
 rtl/load_store_unit.sv | 139 +++++++++++++
 tb/tb_load_store_unit.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - shared encodings and helpers for the load/store unit
package load_store_unit_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam logic [2:0] LD_W   = 3'b000;
   localparam logic [2:0] LD_LB  = 3'b001;
   localparam logic [2:0] LD_LBU = 3'b010;
   localparam logic [2:0] LD_LH  = 3'b011;
   localparam logic [2:0] LD_LHU = 3'b100;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUSY = 2'b01,
      ST_DONE = 2'b10
   } lsu_state_t;

   // Reserved size 2'b11 is handled as a word everywhere.
   function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] offset);
      case (size)
         SZ_BYTE: return 1'b1;
         SZ_HALF: return ~offset[0];
         default: return (offset == 2'b00);
      endcase
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - byte-enable/lane replication for stores and lane extract plus extension for loads
module lsu_lane_align
   import load_store_unit_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  offset,
   input  logic [2:0]  ctrl,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] lanes,
   output logic [31:0] load
);

   logic [7:0]  sel_byte;
   logic [15:0] sel_half;

   always_comb begin
      be    = 4'b1111;
      lanes = wdata;
      case (size)
         SZ_BYTE: begin
            be    = 4'b0001 << offset;
            lanes = {4{wdata[7:0]}};
         end
         SZ_HALF: begin
            be    = 4'b0011 << {offset[1], 1'b0};
            lanes = {2{wdata[15:0]}};
         end
         default: ;
      endcase
   end

   assign sel_byte = rdata[{offset, 3'b000} +: 8];
   assign sel_half = rdata[{offset[1], 4'b0000} +: 16];

   always_comb begin
      load = rdata;
      case (ctrl)
         LD_LB:   load = {{24{sel_byte[7]}}, sel_byte};
         LD_LBU:  load = {24'h000000, sel_byte};
         LD_LH:   load = {{16{sel_half[15]}}, sel_half};
         LD_LHU:  load = {16'h0000, sel_half};
         default: load = rdata;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - turns one load/store into a byte-enabled req/ack bus access, stalling the PC meanwhile
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_read,
   input  logic        MemWrite,
   input  logic [1:0]  operation_byte_size,
   input  logic [2:0]  MemResultCtr,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        stall,
   output logic [31:0] load_data,
   output logic        misaligned,
   output logic        bus_error,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata
);

   localparam int CW = $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   lsu_state_t state, state_next;

   logic [31:0]   addr_q;
   logic [31:0]   wdata_q;
   logic [31:0]   rdata_q;
   logic [1:0]    size_q;
   logic [2:0]    ctrl_q;
   logic          we_q;
   logic          err_q;
   logic [CW-1:0] cnt;

   logic          access;
   logic          aligned;
   logic [3:0]    be_int;
   logic [31:0]   lanes_int;
   logic [31:0]   load_int;

   assign access  = mem_read | MemWrite;
   assign aligned = is_aligned(operation_byte_size, addr[1:0]);

   // Reset is folded in so a held access cannot raise stall/misaligned while in reset.
   always_comb begin
      state_next = state;
      stall      = 1'b0;
      misaligned = 1'b0;
      bus_req    = 1'b0;
      bus_error  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (access && !reset) begin
               if (aligned) begin
                  stall      = 1'b1;
                  state_next = ST_BUSY;
               end else begin
                  misaligned = 1'b1;
               end
            end
         end
         ST_BUSY: begin
            stall   = 1'b1;
            bus_req = 1'b1;
            if (bus_ack || cnt == CNT_LAST)
               state_next = ST_DONE;
         end
         ST_DONE: begin
            bus_error  = err_q;
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= ST_IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         size_q  <= '0;
         ctrl_q  <= '0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         cnt     <= '0;
      end else begin
         state <= state_next;
         case (state)
            ST_IDLE: begin
               if (state_next == ST_BUSY) begin
                  addr_q  <= addr;
                  wdata_q <= wdata;
                  size_q  <= operation_byte_size;
                  ctrl_q  <= MemResultCtr;
                  we_q    <= MemWrite;
                  err_q   <= 1'b0;
                  cnt     <= '0;
               end
            end
            ST_BUSY: begin
               cnt <= cnt + CW'(1);
               // An ack on the last allowed cycle still wins over the timeout.
               if (bus_ack)
                  rdata_q <= bus_rdata;
               else if (cnt == CNT_LAST)
                  err_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   lsu_lane_align u_align (
      .size   (size_q),
      .offset (addr_q[1:0]),
      .ctrl   (ctrl_q),
      .wdata  (wdata_q),
      .rdata  (rdata_q),
      .be     (be_int),
      .lanes  (lanes_int),
      .load   (load_int)
   );

   assign bus_addr  = {addr_q[31:2], 2'b00};
   assign bus_we    = (state == ST_BUSY) & we_q;
   assign bus_be    = (state == ST_BUSY) ? be_int : 4'b0000;
   assign bus_wdata = lanes_int;
   assign load_data = (state == ST_DONE && !err_q) ? load_int : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit with a byte-level memory model
module tb_load_store_unit;

   localparam logic [1:0] S_B = 2'b00, S_H = 2'b01, S_W = 2'b10;
   localparam logic [2:0] C_W = 3'b000, C_LB = 3'b001, C_LBU = 3'b010, C_LH = 3'b011, C_LHU = 3'b100;
   localparam int NO_ACK = 99;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_read;
   logic        MemWrite;
   logic [1:0]  operation_byte_size;
   logic [2:0]  MemResultCtr;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        stall;
   logic [31:0] load_data;
   logic        misaligned;
   logic        bus_error;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   load_store_unit #(.TIMEOUT_CYCLES(16)) dut (
      .clk                 (clk),
      .reset               (reset),
      .mem_read            (mem_read),
      .MemWrite            (MemWrite),
      .operation_byte_size (operation_byte_size),
      .MemResultCtr        (MemResultCtr),
      .addr                (addr),
      .wdata               (wdata),
      .stall               (stall),
      .load_data           (load_data),
      .misaligned          (misaligned),
      .bus_error           (bus_error),
      .bus_req             (bus_req),
      .bus_we              (bus_we),
      .bus_addr            (bus_addr),
      .bus_be              (bus_be),
      .bus_wdata           (bus_wdata),
      .bus_ack             (bus_ack),
      .bus_rdata           (bus_rdata)
   );

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  be;
      logic        we;
      logic [31:0] wdata;
   } bus_exp_t;

   typedef struct {
      bit          mis;
      bit          err;
      bit          is_load;
      logic [31:0] data;
      int          stalls;
      int          reqs;
   } res_exp_t;

   bus_exp_t bus_q[$];
   res_exp_t res_q[$];
   int       delay_q[$];

   logic [7:0]  ref_mem [0:63];
   logic [31:0] slave_mem [0:15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Bus slave: acks on the programmed BUSY cycle, throws spurious acks when idle.
   initial begin
      int cnt;
      int dly;
      cnt = 0;
      dly = NO_ACK;
      bus_ack = 1'b0;
      bus_rdata = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            bus_ack = 1'b0;
            cnt = 0;
         end else if (bus_req) begin
            if (cnt == 0) dly = (delay_q.size() > 0) ? delay_q.pop_front() : NO_ACK;
            cnt++;
            bus_ack = (cnt == dly);
            bus_rdata = bus_ack ? slave_mem[bus_addr[5:2]] : $urandom;
            if (bus_ack && bus_we)
               for (int k = 0; k < 4; k++)
                  if (bus_be[k]) slave_mem[bus_addr[5:2]][8*k +: 8] = bus_wdata[8*k +: 8];
         end else begin
            cnt = 0;
            bus_ack = ($urandom_range(0, 7) == 0);
            bus_rdata = $urandom;
         end
      end
   end

   // Monitor: pops bus expectations on each request and result expectations on each response.
   initial begin
      bus_exp_t cur;
      res_exp_t r;
      bit cur_ok;
      bit in_req;
      bit prev_stall;
      int stall_cnt;
      int req_cnt;
      cur_ok = 0; in_req = 0; prev_stall = 0; stall_cnt = 0; req_cnt = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            in_req = 0; prev_stall = 0; stall_cnt = 0; req_cnt = 0;
         end else begin
            if (stall) stall_cnt++;
            if (bus_req) begin
               if (!in_req) begin
                  checks++;
                  cur_ok = bus_q.size() > 0;
                  if (cur_ok) cur = bus_q.pop_front();
                  else begin
                     errors++;
                     $display("FAIL bus_req: got request at addr 0x%08h expected none", bus_addr);
                  end
                  in_req = 1;
               end
               req_cnt++;
               if (cur_ok) begin
                  chk("bus_addr", bus_addr, cur.addr);
                  chk("bus_be", {28'h0, bus_be}, {28'h0, cur.be});
                  chk("bus_we", {31'h0, bus_we}, {31'h0, cur.we});
                  if (cur.we) chk("bus_wdata", bus_wdata, cur.wdata);
               end
            end else begin
               in_req = 0;
            end
            if (misaligned || (prev_stall && !stall)) begin
               checks++;
               if (res_q.size() == 0) begin
                  errors++;
                  $display("FAIL response: got response with misaligned=%0b expected none", misaligned);
               end else begin
                  r = res_q.pop_front();
                  chk("misaligned", {31'h0, misaligned}, {31'h0, r.mis});
                  chk("bus_error", {31'h0, bus_error}, {31'h0, r.err});
                  if (r.is_load) chk("load_data", load_data, r.data);
                  chk("stall_cycles", stall_cnt, r.stalls);
                  chk("req_cycles", req_cnt, r.reqs);
               end
               stall_cnt = 0;
               req_cnt = 0;
            end
            prev_stall = stall;
         end
      end
   end

   task automatic idle_inputs();
      mem_read = 1'b0;
      MemWrite = 1'b0;
      operation_byte_size = 2'($urandom);
      MemResultCtr = 3'($urandom);
      addr = $urandom;
      wdata = $urandom;
   endtask

   // Called at posedge+1; returns at posedge+1 after the access has finished.
   task automatic do_op(input bit ld, input bit st, input logic [1:0] sz, input logic [2:0] ctrl,
                        input logic [31:0] a, input logic [31:0] wd, input int dly, input bit rst_mid);
      bus_exp_t b;
      res_exp_t r;
      int n, off, idx, nb, guard;
      bit mis, err;
      logic [31:0] v;
      n   = (sz == S_B) ? 1 : (sz == S_H) ? 2 : 4;
      off = int'(a[1:0]);
      idx = int'(a - 32'h100);
      mis = (off % n) != 0;
      err = dly > 16;
      r.mis = mis;
      r.err = !mis && err;
      r.is_load = !st && !mis;
      r.stalls = mis ? 0 : (err ? 17 : 1 + dly);
      r.reqs = mis ? 0 : (err ? 16 : dly);
      r.data = 32'h0;
      if (!mis) begin
         b.addr = a & ~32'h3;
         b.we = st;
         b.be = 4'h0;
         b.wdata = 32'h0;
         for (int i = 0; i < 4; i++) begin
            b.be[i] = (i >= off) && (i < off + n);
            b.wdata[8*i +: 8] = wd[8*(i % n) +: 8];
         end
         bus_q.push_back(b);
         delay_q.push_back(dly);
         if (!st && !err) begin
            nb = (ctrl == C_LB || ctrl == C_LBU) ? 1 : (ctrl == C_LH || ctrl == C_LHU) ? 2 : 4;
            v = 32'h0;
            for (int i = 0; i < nb; i++) v = v | (32'(ref_mem[idx + i]) << (8 * i));
            if (ctrl == C_LB && v[7]) v = v | 32'hFFFFFF00;
            if (ctrl == C_LH && v[15]) v = v | 32'hFFFF0000;
            r.data = v;
         end
         if (st && !err && !rst_mid)
            for (int i = 0; i < n; i++) ref_mem[idx + i] = wd[8*i +: 8];
      end
      if (!rst_mid) res_q.push_back(r);
      mem_read = ld;
      MemWrite = st;
      operation_byte_size = sz;
      MemResultCtr = ctrl;
      addr = a;
      wdata = wd;
      if (rst_mid) begin
         @(posedge clk);
         @(posedge clk);
         #3;
         reset = 1'b1;
         #1;
         chk("stall_in_reset", {31'h0, stall}, 32'h0);
         chk("bus_req_in_reset", {31'h0, bus_req}, 32'h0);
         @(posedge clk);
         #1;
         idle_inputs();
         reset = 1'b0;
      end else begin
         guard = 0;
         do begin
            @(negedge clk);
            guard++;
         end while (stall && guard < 40);
         if (guard >= 40) begin
            checks++;
            errors++;
            $display("FAIL op_timeout: got stall stuck for %0d cycles expected release", guard);
         end
         @(posedge clk);
         #1;
         idle_inputs();
      end
   endtask

   initial begin
      bit ld, st;
      logic [1:0] s;
      logic [2:0] c;
      int d, pick;
      for (int i = 0; i < 64; i++) ref_mem[i] = 8'h00;
      for (int i = 0; i < 16; i++) slave_mem[i] = 32'h0;
      reset = 1'b1;
      idle_inputs();
      mem_read = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("rst_stall", {31'h0, stall}, 32'h0);
      chk("rst_misaligned", {31'h0, misaligned}, 32'h0);
      chk("rst_bus_error", {31'h0, bus_error}, 32'h0);
      chk("rst_bus_req", {31'h0, bus_req}, 32'h0);
      chk("rst_bus_we", {31'h0, bus_we}, 32'h0);
      chk("rst_bus_addr", bus_addr, 32'h0);
      chk("rst_bus_be", {28'h0, bus_be}, 32'h0);
      chk("rst_bus_wdata", bus_wdata, 32'h0);
      chk("rst_load_data", load_data, 32'h0);
      idle_inputs();
      reset = 1'b0;
      @(posedge clk);
      #1;

      do_op(0, 1, S_W, C_W, 32'h100, 32'hDEADBEEF, 3, 0);
      do_op(0, 1, S_B, C_W, 32'h103, 32'h000000A5, 1, 0);
      do_op(1, 0, S_W, C_W, 32'h100, 32'h0, 2, 0);
      do_op(0, 1, S_W, C_W, 32'h100, 32'h00F30000, 2, 0);
      do_op(1, 0, S_B, C_LB, 32'h102, 32'h0, 1, 0);
      do_op(1, 0, S_B, C_LBU, 32'h102, 32'h0, 2, 0);
      do_op(1, 0, S_H, C_LH, 32'h102, 32'h0, 1, 0);
      do_op(1, 0, S_W, C_W, 32'h101, 32'h0, 1, 0);
      do_op(1, 0, S_H, C_LHU, 32'h103, 32'h0, 1, 0);
      do_op(1, 0, S_W, C_W, 32'h100, 32'h0, NO_ACK, 0);
      do_op(1, 0, S_W, C_W, 32'h100, 32'h0, 16, 0);
      do_op(1, 1, S_H, C_LHU, 32'h10A, 32'h1234C0DE, 2, 0);
      do_op(1, 0, S_H, C_LHU, 32'h10A, 32'h0, 1, 0);
      do_op(1, 0, S_W, C_W, 32'h104, 32'h0, NO_ACK, 1);
      do_op(1, 0, S_W, C_W, 32'h108, 32'h0, 1, 0);

      for (int k = 0; k < 150; k++) begin
         st = ($urandom_range(0, 1) == 1);
         ld = !st || ($urandom_range(0, 3) == 0);
         c = 3'($urandom);
         if (st) s = 2'($urandom);
         else if (c == C_LB || c == C_LBU) s = S_B;
         else if (c == C_LH || c == C_LHU) s = S_H;
         else s = ($urandom_range(0, 1) == 1) ? 2'b11 : S_W;
         pick = $urandom_range(0, 19);
         d = (pick == 0) ? NO_ACK : (pick == 1) ? 16 : $urandom_range(1, 5);
         do_op(ld, st, s, c, 32'h100 + 32'($urandom_range(0, 63)), $urandom, d, 0);
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
      end

      repeat (4) @(posedge clk);
      chk("bus_q_drained", bus_q.size(), 32'h0);
      chk("res_q_drained", res_q.size(), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no completion expected $finish");
      $fatal(1);
   end

endmodule
